// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command decoder: opcodes, framing bytes,
// parse FSM states and the tagged response-queue entry.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [7:0] {
    OP_SET_DIV     = 8'h01,
    OP_SET_MASK    = 8'h02,
    OP_SET_VAL     = 8'h03,
    OP_ARM         = 8'h04,
    OP_CLEAR       = 8'h05,
    OP_READ_STATUS = 8'h06
  } opcode_e;

  typedef enum logic [3:0] {
    S_SYNC,
    S_OP,
    S_ARGH,
    S_ARGL,
    S_CHK,
    S_EXEC,
    S_TX_LOAD,
    S_TX_HOLD,
    S_TX_DRAIN
  } state_e;

  // is_status marks the READ_STATUS byte so the sticky drop flag can be released on load
  typedef struct packed {
    logic       is_status;
    logic [7:0] data;
  } resp_t;

  function automatic logic op_valid(input logic [7:0] op);
    return (op >= OP_SET_DIV) && (op <= OP_READ_STATUS);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between the decoder and the UART rx/tx paths.
// master = decoder side, slave = UART side.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start
  );
endinterface

// File: rtl/uart_cmd_decoder_resp_queue.sv
// Two-entry in-order response FIFO; up to two bytes may be pushed in one cycle
// so an ACK and its status byte enter together.
module uart_resp_queue #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       push_cnt_i,
  input  logic [WIDTH-1:0] push_data0_i,
  input  logic [WIDTH-1:0] push_data1_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic [1:0]       cnt;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    cnt   = count_q;
    if (pop_i && cnt != 2'd0) begin
      mem_d[0] = mem_q[1];
      cnt      = cnt - 2'd1;
    end
    if (push_cnt_i != 2'd0 && cnt != 2'd2) begin
      mem_d[cnt[0]] = push_data0_i;
      cnt           = cnt + 2'd1;
    end
    if (push_cnt_i == 2'd2 && cnt != 2'd2) begin
      mem_d[cnt[0]] = push_data1_i;
      cnt           = cnt + 2'd1;
    end
    count_d = cnt;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // NOTE: storage is not reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 5-byte command frames from the UART, drives capture configuration and
// answers via the tx handshake. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int          INPUT_CLK_KHZ = 100_000,
  parameter int          TIMEOUT_MS    = 10,
  parameter logic [15:0] DIV_RESET     = 16'd1
) (
  input  logic               input_clk,
  input  logic               reset_n,
  uart_cmd_decoder_if.master uart,
  input  logic [6:0]         status_in,
  output logic [15:0]        cfg_clk_div,
  output logic [7:0]         cfg_trig_mask,
  output logic [7:0]         cfg_trig_val,
  output logic               arm_pulse,
  output logic               clear_pulse
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, argh_q, argl_q, chk_q;
  logic        hold_q, rx_drop_q, tx_start_q;
  logic [7:0]  tx_data_q;
  logic [15:0] clk_div_q;
  logic [7:0]  trig_mask_q, trig_val_q;

  logic        frame_ok, in_frame, in_resp, load, drop_evt, timeout_hit;
  logic [1:0]  push_cnt, q_count;
  resp_t       push0, push1, head;

  assign in_frame = state_q inside {S_OP, S_ARGH, S_ARGL, S_CHK};
  assign in_resp  = state_q inside {S_EXEC, S_TX_LOAD, S_TX_HOLD, S_TX_DRAIN};

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_CLKS = 32'(INPUT_CLK_KHZ * TIMEOUT_MS);
  logic [31:0] tmr_q;

  always_ff @(posedge input_clk) begin
    if (!reset_n || !in_frame || uart.rx_valid) tmr_q <= '0;
    else                                        tmr_q <= tmr_q + 32'd1;
  end

  assign timeout_hit = in_frame && (tmr_q == TIMEOUT_CLKS - 32'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte arriving while responding, or as a timeout abandons the frame, is lost.
  assign drop_evt = uart.rx_valid && (in_resp || timeout_hit);

  always_ff @(posedge input_clk) begin
    if (!reset_n) state_q <= S_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:     if (uart.rx_valid && uart.rx_data == SYNC_BYTE) state_d = S_OP;
      S_OP:       if (uart.rx_valid) state_d = S_ARGH;
      S_ARGH:     if (uart.rx_valid) state_d = S_ARGL;
      S_ARGL:     if (uart.rx_valid) state_d = S_CHK;
      S_CHK:      if (uart.rx_valid) state_d = S_EXEC;
      S_EXEC:     state_d = S_TX_LOAD;
      S_TX_LOAD:  if (!uart.tx_busy) state_d = S_TX_HOLD;
      S_TX_HOLD:  if (hold_q) state_d = S_TX_DRAIN;
      S_TX_DRAIN: if (!uart.tx_busy) state_d = (q_count != 2'd0) ? S_TX_LOAD : S_SYNC;
      default:    state_d = S_SYNC;
    endcase
    if (timeout_hit) state_d = S_SYNC;
  end

  always_comb begin
    frame_ok         = (chk_q == (op_q ^ argh_q ^ argl_q)) && op_valid(op_q);
    arm_pulse        = 1'b0;
    clear_pulse      = 1'b0;
    push_cnt         = 2'd0;
    push0.is_status  = 1'b0;
    push0.data       = frame_ok ? ACK_BYTE : NAK_BYTE;
    push1.is_status  = 1'b1;
    push1.data       = {rx_drop_q, status_in};
    load             = (state_q == S_TX_LOAD) && !uart.tx_busy;
    if (state_q == S_EXEC) begin
      arm_pulse   = frame_ok && (op_q == OP_ARM);
      clear_pulse = frame_ok && (op_q == OP_CLEAR);
      push_cnt    = (frame_ok && op_q == OP_READ_STATUS) ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge input_clk) begin
    if (uart.rx_valid) begin
      case (state_q)
        S_OP:    op_q   <= uart.rx_data;
        S_ARGH:  argh_q <= uart.rx_data;
        S_ARGL:  argl_q <= uart.rx_data;
        S_CHK:   chk_q  <= uart.rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      hold_q      <= 1'b0;
      rx_drop_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      clk_div_q   <= DIV_RESET;
      trig_mask_q <= 8'h00;
      trig_val_q  <= 8'h00;
    end else begin
      hold_q     <= (state_q == S_TX_HOLD) && !hold_q;
      tx_start_q <= load;
      if (load) tx_data_q <= head.data;
      // A fresh drop wins over releasing the flag for a status byte that reported an older one.
      if (drop_evt)                                     rx_drop_q <= 1'b1;
      else if (load && head.is_status && head.data[7]) rx_drop_q <= 1'b0;
      if (state_q == S_EXEC && frame_ok) begin
        case (op_q)
          OP_SET_DIV:  clk_div_q   <= {argh_q, argl_q};
          OP_SET_MASK: trig_mask_q <= argl_q;
          OP_SET_VAL:  trig_val_q  <= argl_q;
          default:     ;
        endcase
      end
    end
  end

  uart_resp_queue #(.WIDTH($bits(resp_t))) u_resp_queue (
    .clk          (input_clk),
    .rst_n        (reset_n),
    .push_cnt_i   (push_cnt),
    .push_data0_i (push0),
    .push_data1_i (push1),
    .pop_i        (load),
    .head_o       (head),
    .count_o      (q_count)
  );

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign cfg_clk_div   = clk_div_q;
  assign cfg_trig_mask = trig_mask_q;
  assign cfg_trig_val  = trig_val_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder against a frame-level reference model,
// with a behavioural transmitter answering the start/busy handshake.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CLK_KHZ = 1000;
  localparam int TMO_MS  = 1;
`else
  localparam int CLK_KHZ = 100_000;
  localparam int TMO_MS  = 10;
`endif
  localparam logic [15:0] DIV_RST = 16'd1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  status_in;
  logic [15:0] cfg_clk_div;
  logic [7:0]  cfg_trig_mask, cfg_trig_val;
  logic        arm_pulse, clear_pulse;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .INPUT_CLK_KHZ (CLK_KHZ),
    .TIMEOUT_MS    (TMO_MS),
    .DIV_RESET     (DIV_RST)
  ) dut (
    .input_clk     (clk),
    .reset_n       (reset_n),
    .uart          (bus),
    .status_in     (status_in),
    .cfg_clk_div   (cfg_clk_div),
    .cfg_trig_mask (cfg_trig_mask),
    .cfg_trig_val  (cfg_trig_val),
    .arm_pulse     (arm_pulse),
    .clear_pulse   (clear_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: register image, sticky drop flag and counts of expected events.
  logic [15:0] m_div;
  logic [7:0]  m_mask, m_val;
  bit          m_drop;
  int          m_arms = 0, m_clears = 0, m_bytes = 0;

  logic [7:0]  got_q[$];
  int          n_start = 0, arm_seen = 0, clear_seen = 0;

  always @(negedge clk) begin
    if (arm_pulse)    arm_seen++;
    if (clear_pulse)  clear_seen++;
    if (bus.tx_start) n_start++;
  end

  // Transmitter: takes the byte on start, raises busy a cycle later for a random time.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        got_q.push_back(bus.tx_data);
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_div  = DIV_RST;
    m_mask = 8'h00;
    m_val  = 8'h00;
    m_drop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] ah, input logic [7:0] al,
                           input logic [7:0] ck, input int max_gap, input bit inject);
    logic [7:0] exp_resp[$];
    bit         ok;
    int         waited;
    ok = (ck == (op ^ ah ^ al)) && (op >= 8'h01) && (op <= 8'h06);
    send_byte(SYNC_BYTE); gap(max_gap);
    send_byte(op);        gap(max_gap);
    send_byte(ah);        gap(max_gap);
    send_byte(al);        gap(max_gap);
    send_byte(ck);
    check("arm_pulse", arm_pulse, 32'(ok && op == 8'h04));
    check("clear_pulse", clear_pulse, 32'(ok && op == 8'h05));
    @(negedge clk);
    check("arm_width", arm_pulse, 0);
    check("clear_width", clear_pulse, 0);

    exp_resp.push_back(ok ? ACK_BYTE : NAK_BYTE);
    if (ok) begin
      case (op)
        8'h01: m_div  = {ah, al};
        8'h02: m_mask = al;
        8'h03: m_val  = al;
        8'h04: m_arms++;
        8'h05: m_clears++;
        default: begin
          exp_resp.push_back({m_drop, status_in});
          m_drop = 1'b0;
        end
      endcase
    end
    m_bytes += exp_resp.size();

    if (inject) begin
      waited = 0;
      while (!bus.tx_start && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("inject_window", bus.tx_start, 1);
      send_byte(8'($urandom));
      m_drop = 1'b1;
    end

    waited = 0;
    while (got_q.size() < exp_resp.size() && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    waited = 0;
    while (bus.tx_busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);

    check("resp_count", got_q.size(), exp_resp.size());
    for (int i = 0; i < exp_resp.size(); i++) begin
      if (got_q.size() != 0) check("resp_byte", got_q.pop_front(), exp_resp[i]);
    end
    got_q.delete();
    check("cfg_clk_div", cfg_clk_div, m_div);
    check("cfg_trig_mask", cfg_trig_mask, m_mask);
    check("cfg_trig_val", cfg_trig_val, m_val);
  endtask

  initial begin
    int waited;
    int starts_before;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    status_in    = 7'h00;
    reset_n      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_clk_div", cfg_clk_div, DIV_RST);
    check("rst_trig_mask", cfg_trig_mask, 0);
    check("rst_trig_val", cfg_trig_val, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_arm", arm_pulse, 0);
    check("rst_clear", clear_pulse, 0);
    check("rst_fsm", dut.state_q, S_SYNC);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(8'h01, 8'h12, 8'h34, 8'h27, 0, 1'b0);
    run_frame(8'h04, 8'h00, 8'h00, 8'h04, 0, 1'b0);
    run_frame(8'h02, 8'h00, 8'hF0, 8'h00, 0, 1'b0);
    run_frame(8'h05, 8'h00, 8'h00, 8'h05, 0, 1'b1);
    status_in = 7'h41;
    run_frame(8'h06, 8'h00, 8'h00, 8'h06, 0, 1'b0);
    run_frame(8'h06, 8'h00, 8'h00, 8'h06, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      logic [7:0] op, ah, al, ck, g;
      bit         good, inj;
      op = 8'($urandom_range(0, 7));
      ah = 8'($urandom);
      al = 8'($urandom);
      ck = op ^ ah ^ al;
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      status_in = 7'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          g = 8'($urandom);
          if (g == SYNC_BYTE) g = 8'h00;
          send_byte(g);
        end
      end
      good = (ck == (op ^ ah ^ al)) && (op >= 8'h01) && (op <= 8'h06);
      inj  = ($urandom_range(0, 4) == 0) && !(good && op == 8'h06);
      run_frame(op, ah, al, ck, 2, inj);
    end

    // Reset while draining the ACK of a SET_DIV.
    run_frame(8'h02, 8'h00, 8'h5A, 8'h58, 0, 1'b0);
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h67);
    waited = 0;
    while (!bus.tx_start && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_start", bus.tx_start, 1);
    repeat (2) @(negedge clk);
    check("pre_reset_fsm", dut.state_q, S_TX_DRAIN);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_fsm", dut.state_q, S_SYNC);
    check("mid_rst_clk_div", cfg_clk_div, DIV_RST);
    check("mid_rst_trig_mask", cfg_trig_mask, 0);
    starts_before = n_start;
    reset_n = 1'b1;
    model_reset();
    m_bytes += 1;
    repeat (30) @(negedge clk);
    check("post_rst_no_start", n_start, starts_before);
    check("post_rst_resp_count", got_q.size(), 1);
    if (got_q.size() != 0) check("post_rst_resp_byte", got_q.pop_front(), ACK_BYTE);
    got_q.delete();
    run_frame(8'h01, 8'h00, 8'h02, 8'h03, 0, 1'b0);

`ifdef UART_CMD_TIMEOUT_EN
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    repeat (1000) @(negedge clk);
    run_frame(8'h03, 8'h00, 8'h55, 8'h56, 0, 1'b0);
`endif

    check("arm_total", arm_seen, m_arms);
    check("clear_total", clear_seen, m_clears);
    check("start_total", n_start, m_bytes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
